// File: rtl/image_stream_reader_pkg.sv
// Shared defaults, FSM encoding and pipeline constants for the frame reader.
package image_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int DIM_W_DEF  = 10;
    localparam int ADDR_W_DEF = 18;

    // Pixel memory read latency is one cycle plus one output register.
    localparam int RD_LAT    = 2;
    // DRAIN waits exactly as long as the read pipeline so done trails the last pixel.
    localparam int DRAIN_LEN = RD_LAT;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REFRESH = 3'd1,
        READ    = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/image_stream_reader_raster_counter.sv
// Raster position counter: col/row walk over the frame, idx is the linear offset.
module raster_counter
    import image_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);

    localparam logic [DIM_W-1:0] ONE = {{(DIM_W-1){1'b0}}, 1'b1};

    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             col_end;

    assign col_end = (col == width - ONE);
    // High while the current position is the final pixel of the frame.
    assign last    = col_end && (row == height - ONE);

    // Advance one pixel per enabled cycle; col wraps at end of line and bumps row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
            idx <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
            idx <= '0;
        end else if (en) begin
            idx <= idx + 1'b1;
            if (col_end) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

endmodule

// File: rtl/image_stream_reader.sv
// Frame-read sequencer: raster-walks pixel memory and streams pixels to the filter.
module image_stream_reader
    import image_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  image_width,
    input  logic [DIM_W-1:0]  image_height,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pause,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              refresh,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_CW = $clog2(DRAIN_LEN + 1);
    localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN_LEN - 1);

    state_t              state, state_nxt;
    logic [DIM_W-1:0]    width_q, height_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   idx;
    logic                last;
    logic                accept;
    logic                cnt_en;
    logic [DRAIN_CW-1:0] drain_cnt;
    logic [RD_LAT-1:0]   vld_pipe;

    assign accept   = (state == IDLE) && start;
    assign cnt_en   = (state == READ) && !pause;
    assign busy     = (state != IDLE);
    assign mem_addr = base_q + idx;

    raster_counter #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (cnt_en),
        .width  (width_q),
        .height (height_q),
        .idx    (idx),
        .last   (last)
    );

    // Frame geometry is captured once per accepted start and held for the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_q  <= '0;
            height_q <= '0;
            base_q   <= '0;
        end else if (accept) begin
            width_q  <= image_width;
            height_q <= image_height;
            base_q   <= base_addr;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // DRAIN cycle counter, cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 drain_cnt <= '0;
        else if (state == DRAIN)  drain_cnt <= drain_cnt + 1'b1;
        else                      drain_cnt <= '0;
    end

    // Next-state and strobe decode; empty frames skip straight to DONE.
    always_comb begin
        state_nxt = state;
        refresh   = 1'b0;
        mem_rd    = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (image_width == '0 || image_height == '0) state_nxt = DONE;
                    else                                          state_nxt = REFRESH;
                end
            end
            REFRESH: begin
                refresh   = 1'b1;
                state_nxt = READ;
            end
            READ: begin
                if (!pause) begin
                    mem_rd = 1'b1;
                    if (last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Valid tracks mem_rd through the memory cycle and the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_pipe <= '0;
        else      vld_pipe <= {vld_pipe[RD_LAT-2:0], mem_rd};
    end

    // Capture read data in the cycle after the read; hold it otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             data_out <= '0;
        else if (vld_pipe[0]) data_out <= mem_rdata;
    end

    assign data_valid = vld_pipe[RD_LAT-1];

endmodule

// File: tb/tb_image_stream_reader.sv
// Frame reader bench: vector table of frames, scoreboard of addresses and pixels.
module tb_image_stream_reader;

    localparam int DATA_W = 10;
    localparam int DIM_W  = 10;
    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DIM_W-1:0]  image_width;
    logic [DIM_W-1:0]  image_height;
    logic [ADDR_W-1:0] base_addr;
    logic              pause;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              refresh;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    typedef struct {
        string             name;
        int                w;
        int                h;
        logic [ADDR_W-1:0] base;
        int                p_at;
        int                p_len;
        int                restart;
        int                exp_done;
    } vec_t;

    vec_t vecs[6];

    image_stream_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .image_width  (image_width),
        .image_height (image_height),
        .base_addr    (base_addr),
        .pause        (pause),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .refresh      (refresh),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Pixel memory: each word holds the low 10 bits of its own address.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_addr[DATA_W-1:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_mem_rd"},     mem_rd,     0);
        chk({name, "_data_valid"}, data_valid, 0);
        chk({name, "_refresh"},    refresh,    0);
        chk({name, "_done"},       done,       0);
        chk({name, "_busy"},       busy,       0);
        chk({name, "_data_out"},   data_out,   0);
        chk({name, "_mem_addr"},   mem_addr,   0);
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        int ref_cnt, ref_cyc, done_cyc, first_rd, first_vld, busy_low, stray;
        logic [ADDR_W-1:0] a;
        n = v.w * v.h;
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < n; i++) begin
            a = v.base + ADDR_W'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(a[DATA_W-1:0]);
        end
        ref_cnt = 0; ref_cyc = -1; done_cyc = -1;
        first_rd = -1; first_vld = -1; busy_low = 0; stray = 0;

        @(negedge clk);
        image_width  = DIM_W'(v.w);
        image_height = DIM_W'(v.h);
        base_addr    = v.base;
        start        = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = (cyc == v.restart);
            pause = (cyc >= v.p_at) && (cyc < v.p_at + v.p_len);
            #1;
            if (!busy) busy_low++;
            if (refresh) begin ref_cnt++; ref_cyc = cyc; end
            if (mem_rd) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr_q.size() == 0) stray++;
                else chk({v.name, "_addr"}, mem_addr, exp_addr_q.pop_front());
            end
            if (data_valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (exp_data_q.size() == 0) stray++;
                else chk({v.name, "_pixel"}, data_out, exp_data_q.pop_front());
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        pause = 1'b0;

        chk({v.name, "_done_cycle"}, done_cyc, v.exp_done);
        chk({v.name, "_refresh_cnt"}, ref_cnt, (n > 0) ? 1 : 0);
        chk({v.name, "_reads_left"}, exp_addr_q.size(), 0);
        chk({v.name, "_pixels_left"}, exp_data_q.size(), 0);
        chk({v.name, "_stray"}, stray, 0);
        chk({v.name, "_busy_gap"}, busy_low, 0);
        if (n > 0) begin
            chk({v.name, "_refresh_cycle"}, ref_cyc, 1);
            chk({v.name, "_first_rd"}, first_rd, 2);
            chk({v.name, "_first_valid"}, first_vld, 4);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk({v.name, "_post_quiet"},
                {busy, done, refresh, mem_rd, data_valid}, 0);
        end
    endtask

    initial begin
        vecs[0] = '{"basic_4x3",   4, 3, 18'h00100, 0, 0, 0, 16};
        vecs[1] = '{"pause_r1c2",  4, 3, 18'h00100, 8, 3, 0, 19};
        vecs[2] = '{"one_by_one",  1, 1, 18'h00055, 0, 0, 0, 5};
        vecs[3] = '{"width_zero",  0, 3, 18'h00100, 0, 0, 0, 1};
        vecs[4] = '{"addr_wrap",   4, 1, 18'h3FFFE, 0, 0, 0, 8};
        vecs[5] = '{"start_busy",  4, 3, 18'h00100, 0, 0, 5, 16};

        rst          = 1'b0;
        start        = 1'b0;
        pause        = 1'b0;
        image_width  = '0;
        image_height = '0;
        base_addr    = '0;
        #1;
        chk_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Reset dropped mid-READ, then the same frame is replayed from (0,0).
        @(negedge clk);
        image_width  = 10'd4;
        image_height = 10'd3;
        base_addr    = 18'h00100;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("midrst_in_read", mem_rd, 1);
        rst = 1'b0;
        #1;
        chk_idle_outputs("midrst_now");
        @(negedge clk);
        #1;
        chk_idle_outputs("midrst_hold");
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_after_release", {busy, done, refresh, mem_rd, data_valid}, 0);
        run_frame('{"replay", 4, 3, 18'h00100, 0, 0, 0, 16});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_stream_reader.md
# image_stream_reader

Frame-read sequencer upstream of `filter_unit`. On `start` it walks a stored image in raster order through a synchronous single-port pixel memory. It streams each pixel into the filter's `data_in` with a valid strobe. It pulses the filter's `refresh` input one cycle before the first pixel of every frame, so the line buffers restart cleanly. It also reports `busy` and `done` to the frame controller.

## Interface
- `DATA_W`, 10, pixel width (matches `filter_unit` data path)
- `DIM_W`, 10, width of `image_width` / `image_height`
- `ADDR_W`, 18, pixel memory address width
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle frame request, sampled only in IDLE
- `image_width` in DIM_W: pixels per line, latched on accepted `start`
- `image_height` in DIM_W: lines per frame, latched on accepted `start`
- `base_addr` in ADDR_W: address of pixel (0,0), latched on accepted `start`
- `pause` in 1: when high in READ, no read is issued and the counters hold
- `mem_addr` out ADDR_W: read address to the pixel memory
- `mem_rd` out 1: read enable; `mem_rdata` is valid in the following cycle
- `mem_rdata` in DATA_W: read data from the pixel memory
- `data_out` out DATA_W: pixel to `filter_unit.data_in`
- `data_valid` out 1: `data_out` holds a new pixel this cycle
- `refresh` out 1: one-cycle pulse to `filter_unit.refresh`
- `busy` out 1: high whenever state ≠ IDLE
- `done` out 1: one-cycle pulse after the last pixel has left `data_out`

## Operation
- Reset value of every output is 0. While `rst` is low, the FSM is in IDLE and all counters and registers are 0.
- **IDLE:** `start`=1 with width≥1 and height≥1 latches the inputs, clears col/row/idx, and goes to REFRESH. `start` with width=0 or height=0 goes straight to DONE, with no `refresh` and no reads.
- **REFRESH:** `refresh`=1 for exactly this cycle; next state is READ.
- **READ, `pause`=0:**
  - `mem_rd`=1 and `mem_addr` = `base_addr` + idx, modulo 2^ADDR_W (wrap-around allowed).
  - idx increments by 1.
  - col increments; at col = width−1 it wraps to 0 and row increments.
  - The read of (height−1, width−1) moves the FSM to DRAIN.
- **READ, `pause`=1:** `mem_rd`=0; `mem_addr`, col, row and idx hold.
- **DRAIN:** 2 cycles, no reads, `pause` ignored; then DONE.
- **DONE:** `done`=1 for one cycle; then IDLE.
- **Output stage:** `data_out` and `data_valid` are registered. `data_valid` = `mem_rd` delayed 2 cycles; `data_out` = `mem_rdata` registered. `data_out` holds its last value when `data_valid`=0.
- `start` while `busy` is ignored (no queueing).
- Reset mid-frame: the in-flight reads are discarded and the next cycle shows no `data_valid`, `refresh` or `done`.

## Timing
- `start` sampled at edge 0: `refresh` high in cycle 1, first `mem_rd` in cycle 2, first `data_valid` in cycle 4.
- N = width×height, no pause: `mem_rd` in cycles 2..N+1, `data_valid` in 4..N+3, `done` in N+4, `busy` in 1..N+4.
- Each pause cycle inside READ shifts all subsequent events by 1 cycle.
- Latency from `mem_rd` to `data_valid` is fixed at 2 cycles.
- Counter widths: col/row are DIM_W; idx is ADDR_W. Width 1 or height 1 must still work: col wraps every cycle / a single row.

## Structure
- Package `image_pkg` holds:
  - the `DATA_W`/`DIM_W`/`ADDR_W` defaults;
  - the state encoding constants IDLE, REFRESH, READ, DRAIN, DONE;
  - the DRAIN length constant, set to 2 (equal to the read latency).
- One sub-module, `raster_counter`, contains col/row/idx with clear, enable and a `last` flag. The FSM and the output register stage stay in the top module.

## Test plan
- **Basic 4×3 frame:** `base_addr`=0x100, memory holds addr[9:0], start, no pause. Expect:
  - `refresh` in cycle 1;
  - 12 `data_valid` pulses, data 0x100..0x10B in order;
  - `done` in cycle 16.
- **Pause during row 1, col 2, held 3 cycles:** the address sequence is unchanged with no gaps or duplicates, and `done` moves to cycle 19.
- **Degenerate sizes:**
  - 1×1 frame gives exactly 1 pixel, with `done` in cycle 5.
  - width=0 gives `done` in cycle 1, no `refresh` and no `mem_rd`.
- **Address wrap:** `base_addr`=0x3FFFE with a 4×1 frame produces addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- **Reset mid-frame:** drop `rst` during READ. All outputs go to 0 immediately and stay idle. A new start then replays the frame from pixel (0,0), preceded by `refresh`.
- **Start while busy:** a second `start` pulse in cycle 5 of a 4×3 frame has no effect. Exactly 12 pixels come out and there is a single `done`.
